group_scan_scheduler: RTL

- Sequencer for the naked/hidden group detector. Walks the detector across all 81 cells of the possible-values grid, one cell per request/acknowledge transaction.
- Commits every grid change the detector reports, and repeats full passes until a pass makes no change or a pass limit is reached.
- Sits between the top-level solver FSM (start/done) and the group detection datapath (load/req/ack/commit).

---
 rtl/group_scan_scheduler.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/group_scan_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : group_scan_scheduler
// Description : Walks the naked/hidden group detector over every cell of the
//               possible-values grid. One request/acknowledge transaction is
//               made per cell, and each reported change is committed. Full
//               passes repeat until a pass makes no change or the pass limit
//               is reached.
// Options     : GROUP_SCAN_TIMEOUT_EN adds an acknowledge watchdog with a
//               sticky error_out.
// Revision    : 1.0 - initial release
// ============================================================================
module group_scan_scheduler #(
  parameter int GRID_SIZE      = 9,
  parameter int MAX_PASSES     = 15,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       start_in,
  output logic       busy_out,
  output logic       done_out,
  output logic       converged_out,
  output logic [3:0] pass_count_out,
  output logic [7:0] naked_hits_out,
  output logic [7:0] hidden_hits_out,
  output logic       load_out,
  output logic       det_req_out,
  output logic [3:0] det_row_out,
  output logic [3:0] det_col_out,
  input  logic       det_ack_in,
  input  logic       det_naked_in,
  input  logic       det_hidden_in,
  input  logic       det_changed_in,
  output logic       commit_out,
  output logic       error_out
);

  localparam logic [3:0] c_LAST = 4'(GRID_SIZE - 1);
  localparam logic [4:0] c_MAX  = 5'(MAX_PASSES);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_ISSUE    = 3'd2,
    S_COMMIT   = 3'd3,
    S_NEXT     = 3'd4,
    S_PASS_END = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_row;
  logic [3:0] r_col;
  logic [3:0] r_pass_count;
  logic [7:0] r_naked;
  logic [7:0] r_hidden;
  logic       r_pass_changed;
  logic       r_converged;
  logic       r_error;
  logic       w_last_cell;
  logic       w_take;
  logic       w_tmo;
  logic [4:0] w_pass_inc;

  assign w_last_cell = (r_row == c_LAST) && (r_col == c_LAST);
  // A detector result only counts when it is acknowledged while a request is out.
  assign w_take      = (r_state == S_ISSUE) && det_ack_in;
  assign w_pass_inc  = {1'b0, r_pass_count} + 5'd1;

`ifdef GROUP_SCAN_TIMEOUT_EN
  localparam int c_WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT_CYCLES - 1);
  logic [c_WAIT_W-1:0] r_wait;

  // Count unacknowledged request cycles; any ack or leaving ISSUE restarts it.
  always_ff @(posedge clk_in) begin
    if (reset_in || (r_state != S_ISSUE) || det_ack_in) begin
      r_wait <= '0;
    end else begin
      r_wait <= r_wait + c_WAIT_W'(1);
    end
  end

  assign w_tmo = (r_state == S_ISSUE) && !det_ack_in && (r_wait == c_WAIT_LAST);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
  assign w_tmo            = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     w_next = start_in ? S_LOAD : S_IDLE;
      S_LOAD:     w_next = S_ISSUE;
      S_ISSUE: begin
        if (det_ack_in) begin
          w_next = det_changed_in ? S_COMMIT : S_NEXT;
        end else if (w_tmo) begin
          w_next = S_DONE;
        end
      end
      S_COMMIT:   w_next = S_NEXT;
      S_NEXT:     w_next = w_last_cell ? S_PASS_END : S_ISSUE;
      S_PASS_END: w_next = (r_pass_changed && (w_pass_inc < c_MAX)) ? S_LOAD : S_DONE;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Cell position, pass bookkeeping, hit counters and run status.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_row          <= '0;
      r_col          <= '0;
      r_pass_count   <= '0;
      r_naked        <= '0;
      r_hidden       <= '0;
      r_pass_changed <= 1'b0;
      r_converged    <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_in) begin
            r_pass_count <= '0;
            r_naked      <= '0;
            r_hidden     <= '0;
            r_converged  <= 1'b0;
            r_error      <= 1'b0;
          end
        end
        S_LOAD: begin
          r_row          <= '0;
          r_col          <= '0;
          r_pass_changed <= 1'b0;
        end
        S_ISSUE: begin
          if (w_take && det_changed_in) begin
            r_pass_changed <= 1'b1;
            if (det_naked_in && (r_naked != 8'hFF)) begin
              r_naked <= r_naked + 8'd1;
            end
            if (det_hidden_in && (r_hidden != 8'hFF)) begin
              r_hidden <= r_hidden + 8'd1;
            end
          end
          if (w_tmo) begin
            r_error <= 1'b1;
          end
        end
        S_NEXT: begin
          if (!w_last_cell) begin
            if (r_col == c_LAST) begin
              r_col <= '0;
              r_row <= r_row + 4'd1;
            end else begin
              r_col <= r_col + 4'd1;
            end
          end
        end
        S_PASS_END: begin
          r_pass_count <= r_pass_count + 4'd1;
        end
        S_DONE: begin
          // A watchdog abort never reports convergence.
          r_converged <= !r_pass_changed && !r_error;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy_out        = (r_state != S_IDLE);
  assign done_out        = (r_state == S_DONE);
  assign load_out        = (r_state == S_LOAD);
  assign det_req_out     = (r_state == S_ISSUE);
  assign commit_out      = (r_state == S_COMMIT);
  assign det_row_out     = r_row;
  assign det_col_out     = r_col;
  assign converged_out   = r_converged;
  assign pass_count_out  = r_pass_count;
  assign naked_hits_out  = r_naked;
  assign hidden_hits_out = r_hidden;
  assign error_out       = r_error;

endmodule
`default_nettype wire
